system_nios2_qsys_0_div_cell: RTL and testbench



---
 rtl/system_nios2_qsys_0_div_cell_pkg.sv | 26 ++
 rtl/system_nios2_qsys_0_div_step.sv | 22 ++
 rtl/system_nios2_qsys_0_div_cell.sv | 106 ++++++++++
 tb/tb_system_nios2_qsys_0_div_cell.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/system_nios2_qsys_0_div_cell_pkg.sv
// Shared types and helpers for the M-stage iterative divider.
// The sign helpers are sized to the default datapath width.
package system_nios2_qsys_0_div_cell_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_LATENCY    = DIV_DATA_WIDTH + 1;

  localparam logic [DIV_DATA_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic logic [DIV_DATA_WIDTH-1:0] div_neg(input logic [DIV_DATA_WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_DATA_WIDTH-1:0] div_abs(input logic [DIV_DATA_WIDTH-1:0] v,
                                                        input logic                      is_signed);
    return (is_signed && v[DIV_DATA_WIDTH-1]) ? div_neg(v) : v;
  endfunction

endpackage

// File: rtl/system_nios2_qsys_0_div_step.sv
// One restoring-division step: shift in the next dividend bit and
// subtract the divisor if that does not borrow.
module system_nios2_qsys_0_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem,
  input  logic                  dvd_msb,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] trial;

  assign shifted  = {rem, dvd_msb};
  assign trial    = shifted - {2'b00, divisor};
  // Top bit of the trial difference is the borrow.
  assign q_bit    = ~trial[DATA_WIDTH+1];
  assign rem_next = q_bit ? trial[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];

endmodule

// File: rtl/system_nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider for div/divu at the M stage:
// one quotient bit per clock, signs applied in a final FIX cycle.
module system_nios2_qsys_0_div_cell
  import system_nios2_qsys_0_div_cell_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] M_div_src1,
  input  logic [DATA_WIDTH-1:0] M_div_src2,
  input  logic                  M_div_signed,
  input  logic                  M_div_start,
  input  logic                  M_div_abort,
  output logic                  M_div_busy,
  output logic                  M_div_done,
  output logic [DATA_WIDTH-1:0] M_div_cell_result,
  output logic [DATA_WIDTH-1:0] M_div_cell_rem
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  div_state_e            state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH:0]   rem_q, rem_step;
  logic [DATA_WIDTH-1:0] dvd_q, divisor_q;
  logic                  q_neg, r_neg, div0;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] result_q, rem_out_q;
  logic [DATA_WIDTH-1:0] fix_q, fix_r;
  logic                  start_ok;

  system_nios2_qsys_0_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[DATA_WIDTH-1]),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  assign start_ok = M_div_start & ~M_div_abort;

  // dvd_q shifts out dividend bits and shifts in quotient bits, so it
  // holds the quotient magnitude once RUN completes. A zero divisor
  // leaves the dividend magnitude as remainder, which re-signs back to src1.
  assign fix_q = div0  ? DIV0_QUOTIENT
               : q_neg ? div_neg(dvd_q) : dvd_q;
  assign fix_r = r_neg ? div_neg(rem_q[DATA_WIDTH-1:0]) : rem_q[DATA_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (M_div_abort) state_nxt = IDLE;
               else if (cnt == LAST_CNT) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign M_div_busy        = (state == RUN);
  assign M_div_done        = (state == FIX) & ~M_div_abort;
  // Results are visible in the done cycle and held in registers after.
  assign M_div_cell_result = M_div_done ? fix_q : result_q;
  assign M_div_cell_rem    = M_div_done ? fix_r : rem_out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div0      <= 1'b0;
      result_q  <= '0;
      rem_out_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start_ok) begin
          dvd_q     <= div_abs(M_div_src1, M_div_signed);
          divisor_q <= div_abs(M_div_src2, M_div_signed);
          q_neg     <= M_div_signed & (M_div_src1[DATA_WIDTH-1] ^ M_div_src2[DATA_WIDTH-1]);
          r_neg     <= M_div_signed & M_div_src1[DATA_WIDTH-1];
          div0      <= (M_div_src2 == '0);
          rem_q     <= '0;
          cnt       <= '0;
        end
        RUN: begin
          rem_q <= rem_step;
          dvd_q <= {dvd_q[DATA_WIDTH-2:0], q_bit};
          cnt   <= cnt + CNT_WIDTH'(1);
        end
        FIX: if (M_div_done) begin
          result_q  <= fix_q;
          rem_out_q <= fix_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_system_nios2_qsys_0_div_cell.sv
// Directed bench for the iterative divider: a cycle-age timeline model
// plus integer-arithmetic reference, checked every negedge.
module tb_system_nios2_qsys_0_div_cell;
  import system_nios2_qsys_0_div_cell_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        sgn = 1'b0, start = 1'b0, abort = 1'b0;
  logic        busy, done;
  logic [31:0] result, rem;

  system_nios2_qsys_0_div_cell #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .M_div_src1        (src1),
    .M_div_src2        (src2),
    .M_div_signed      (sgn),
    .M_div_start       (start),
    .M_div_abort       (abort),
    .M_div_busy        (busy),
    .M_div_done        (done),
    .M_div_cell_result (result),
    .M_div_cell_rem    (rem)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  int busy_cnt = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference division straight from the arithmetic rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // age: 0 idle, 1..32 iterating, 33 completing.
  int          age = 0;
  logic [31:0] pend_q = '0, pend_r = '0, held_q = '0, held_r = '0;

  always @(posedge clk) begin
    if (!reset_n) age = 0;
    else if (age == 0) begin
      if (start && !abort) begin
        ref_div(src1, src2, sgn, pend_q, pend_r);
        age = 1;
      end
    end else if (abort || age == DIV_LATENCY) age = 0;
    else age++;
  end

  always @(negedge clk) begin
    logic exp_done;
    if (!reset_n) begin
      held_q = '0;
      held_r = '0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rem", rem, 32'd0);
    end else begin
      exp_done = (age == DIV_LATENCY) && !abort;
      chk("busy", 32'(busy), 32'(age >= 1 && age <= DIV_LATENCY - 1));
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        held_q = pend_q;
        held_r = pend_r;
      end
      chk("result", result, held_q);
      chk("rem", rem, held_r);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    src1 = a; src2 = b; sgn = s; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_lit(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er);
    busy_cnt = 0; done_cnt = 0;
    issue(a, b, s);
    tick(DIV_LATENCY + 1);
    chk({nm, "_q"}, result, eq);
    chk({nm, "_r"}, rem, er);
    chk({nm, "_busycycles"}, 32'(busy_cnt), 32'd32);
    chk({nm, "_dones"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    logic [31:0] q, r;
    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
    chk("model_neg_q", q, 32'hFFFF_FFFD);
    chk("model_neg_r", r, 32'hFFFF_FFFF);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
    chk("model_ovf_q", q, 32'h8000_0000);
    chk("model_ovf_r", r, 32'd0);

    #1;
    chk("init_result", result, 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    run_lit("divu_100_7",  32'd100,       32'd7,         1'b0, 32'd14,        32'd2);
    run_lit("div_m7_2",    32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_lit("divu_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'd1);
    run_lit("div_7_m2",    32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_lit("divu_5_0",    32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5);
    run_lit("div_m5_0",    32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    run_lit("div_ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_lit("divu_max_1",  32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0);

    // A second start while busy must be dropped.
    busy_cnt = 0; done_cnt = 0;
    issue(32'd1000, 32'd10, 1'b0);
    tick(9);
    src1 = 32'd7; src2 = 32'd7; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(DIV_LATENCY + 5);
    chk("busystart_q", result, 32'd100);
    chk("busystart_r", rem, 32'd0);
    chk("busystart_dones", 32'(done_cnt), 32'd1);

    // Abort mid-run: no done, outputs keep the previous result.
    done_cnt = 0;
    issue(32'd50, 32'd3, 1'b0);
    tick(9);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy_next", 32'(busy), 32'd0);
    tick(DIV_LATENCY + 5);
    chk("abort_dones", 32'(done_cnt), 32'd0);
    chk("abort_q", result, 32'd100);
    chk("abort_r", rem, 32'd0);

    // start and abort together in IDLE starts nothing.
    busy_cnt = 0; done_cnt = 0;
    src1 = 32'd9; src2 = 32'd3; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(DIV_LATENCY + 2);
    chk("startabort_busy", 32'(busy_cnt), 32'd0);
    chk("startabort_dones", 32'(done_cnt), 32'd0);

    // Asynchronous reset mid-operation clears outputs at once.
    issue(32'd9, 32'd2, 1'b0);
    tick(3);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rem", rem, 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    run_lit("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
